scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_pkg.sv | 26 ++
 rtl/scan_decoder_timer.sv | 27 ++
 rtl/scan_decoder.sv | 157 +++++++++++++++
 tb/tb_scan_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: FSM state encoding and
// the index-to-line decode with output polarity applied.
package scan_decoder_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_N     = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_BLANK
  } state_t;

  // Callers truncate the result to their own line count.
  function automatic logic [MAX_N-1:0] line_onehot(
    input logic [MAX_SEL_W-1:0] sel,
    input logic                 on,
    input logic                 act_low
  );
    logic [MAX_N-1:0] v;
    v = '0;
    if (on) v[sel] = 1'b1;
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/scan_decoder_timer.sv
// Dwell/blank down-counter: load a value, count to zero, flag done at zero.
module scan_decoder_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot line decoder with direct select and timed scan modes,
// inserting all-inactive blank cycles between any two active lines.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned BLANK      = 1,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      d,
  input  logic                  d_valid,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  active,
  output logic                  wrap
);

  localparam int unsigned N_OUT = 2 ** SEL_W;
  localparam int unsigned T_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam logic [N_OUT-1:0] Y_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t           state, state_nx;
  logic [SEL_W-1:0] idx_nx, pend, pend_nx;
  logic             pend_valid, pend_valid_nx;
  logic             scanning, scanning_nx;
  logic             wrap_nx, req;
  logic [N_OUT-1:0] y_nx;
  logic             t_clr, t_load, t_done;
  logic [TW-1:0]    t_val;

  scan_decoder_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (t_clr),
    .load  (t_load),
    .value (t_val),
    .done  (t_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      scanning   <= 1'b0;
      y          <= Y_OFF;
      active     <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      pend       <= pend_nx;
      pend_valid <= pend_valid_nx;
      scanning   <= scanning_nx;
      y          <= y_nx;
      active     <= (state_nx == ST_DRIVE);
      wrap       <= wrap_nx;
    end
  end

  // Outputs are decoded from the next state so y, idx and active change together.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    pend_nx       = pend;
    pend_valid_nx = pend_valid;
    scanning_nx   = scanning;
    wrap_nx       = 1'b0;
    t_clr         = 1'b0;
    t_load        = 1'b0;
    t_val         = '0;
    req           = !mode && d_valid;

    if (!en) begin
      state_nx      = ST_IDLE;
      pend_valid_nx = 1'b0;
      scanning_nx   = 1'b0;
      t_clr         = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mode) begin
            state_nx    = ST_DRIVE;
            idx_nx      = '0;
            scanning_nx = 1'b1;
            t_load      = 1'b1;
            t_val       = TW'(DWELL - 1);
          end else if (d_valid) begin
            state_nx    = ST_DRIVE;
            idx_nx      = d;
            scanning_nx = 1'b0;
          end
        end
        ST_DRIVE: begin
          if (mode != scanning) begin
            state_nx      = ST_BLANK;
            t_load        = 1'b1;
            t_val         = TW'(BLANK - 1);
            pend_nx       = d;
            pend_valid_nx = req;
          end else if (scanning) begin
            if (t_done) begin
              state_nx = ST_BLANK;
              t_load   = 1'b1;
              t_val    = TW'(BLANK - 1);
            end
          end else if (d_valid && (d != idx)) begin
            state_nx      = ST_BLANK;
            t_load        = 1'b1;
            t_val         = TW'(BLANK - 1);
            pend_nx       = d;
            pend_valid_nx = 1'b1;
          end
        end
        ST_BLANK: begin
          if (req) begin
            pend_nx       = d;
            pend_valid_nx = 1'b1;
          end
          if (t_done) begin
            if (mode) begin
              state_nx = ST_DRIVE;
              t_load   = 1'b1;
              t_val    = TW'(DWELL - 1);
              if (scanning) begin
                idx_nx  = idx + 1'b1;
                wrap_nx = &idx;
              end else begin
                idx_nx      = '0;
                scanning_nx = 1'b1;
              end
            end else if (pend_valid_nx) begin
              state_nx      = ST_DRIVE;
              idx_nx        = pend_nx;
              scanning_nx   = 1'b0;
              pend_valid_nx = 1'b0;
            end else begin
              state_nx    = ST_IDLE;
              scanning_nx = 1'b0;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    y_nx = N_OUT'(line_onehot(MAX_SEL_W'(idx_nx), state_nx == ST_DRIVE, ACTIVE_LOW != 0));
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default build plus a 16-line active-high build.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: SEL_W=3, DWELL=4, BLANK=1, active-low
  logic       rst1, en1, mode1, dv1;
  logic [2:0] d1, idx1;
  logic [7:0] y1;
  logic       act1, wrap1;

  scan_decoder u1 (
    .clk(clk), .rst_n(rst1), .en(en1), .mode(mode1), .d(d1), .d_valid(dv1),
    .y(y1), .idx(idx1), .active(act1), .wrap(wrap1)
  );

  // variant: SEL_W=4, active-high, DWELL=1
  logic        rst2, en2, mode2, dv2;
  logic [3:0]  d2, idx2;
  logic [15:0] y2;
  logic        act2, wrap2;

  scan_decoder #(.SEL_W(4), .DWELL(1), .BLANK(1), .ACTIVE_LOW(0)) u2 (
    .clk(clk), .rst_n(rst2), .en(en2), .mode(mode2), .d(d2), .d_valid(dv2),
    .y(y2), .idx(idx2), .active(act2), .wrap(wrap2)
  );

  int checks = 0;
  int errors = 0;
  logic inv_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // at most one line active, and active flags exactly that case
  always @(negedge clk) begin
    if (inv_on) begin
      check("onehot_u1", 32'($countones(~y1)), {31'd0, act1});
      check("onehot_u2", 32'($countones(y2)), {31'd0, act2});
    end
  end

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] d;
    logic       dv;
    logic [7:0] y;
    logic [2:0] idx;
    logic       act;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // inputs for the cycle -> expected outputs after that edge
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 8'hDF, 3'd5, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 8'hDF, 3'd5, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 8'hDF, 3'd5, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 8'hFF, 3'd5, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 8'hFB, 3'd2, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 8'hFF, 3'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 8'hEF, 3'd4, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 8'hFF, 3'd4, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'hFF, 3'd4, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'hFD, 3'd1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 8'hFF, 3'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 8'hBF, 3'd6, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 8'hFF, 3'd6, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'hFF, 3'd0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 8'hFF, 3'd0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 8'hF7, 3'd3, 1'b1};

    rst1 = 1'b0; en1 = 1'b0; mode1 = 1'b0; d1 = '0; dv1 = 1'b0;
    rst2 = 1'b0; en2 = 1'b0; mode2 = 1'b0; d2 = '0; dv2 = 1'b0;

    for (int i = 0; i < 19; i++) begin
      rst1 = tbl[i].rst_n; en1 = tbl[i].en; mode1 = tbl[i].mode;
      d1 = tbl[i].d; dv1 = tbl[i].dv;
      step();
      inv_on = 1'b1;
      check($sformatf("row%0d_y", i),    {24'd0, y1},   {24'd0, tbl[i].y});
      check($sformatf("row%0d_idx", i),  {29'd0, idx1}, {29'd0, tbl[i].idx});
      check($sformatf("row%0d_act", i),  {31'd0, act1}, {31'd0, tbl[i].act});
      check($sformatf("row%0d_wrap", i), {31'd0, wrap1}, 32'd0);
    end

    // direct DRIVE idx=3 -> scan: one blank, then restart at 0 without wrap
    mode1 = 1'b1; dv1 = 1'b1; d1 = 3'd6;
    step();
    check("mchg_y", {24'd0, y1}, 32'hFF);
    check("mchg_idx", {29'd0, idx1}, 32'd3);
    step();
    check("scan0_y", {24'd0, y1}, 32'hFE);
    check("scan0_idx", {29'd0, idx1}, 32'd0);
    check("scan0_wrap", {31'd0, wrap1}, 32'd0);
    dv1 = 1'b0;
    for (int p = 1; p <= 95; p++) begin
      int pos, li;
      logic drv, wr;
      logic [7:0] ey;
      step();
      pos = p % 40;
      li  = pos / 5;
      drv = (pos % 5) < 4;
      wr  = (pos == 0);
      ey  = drv ? ~(8'd1 << li) : 8'hFF;
      check($sformatf("scan%0d_y", p),    {24'd0, y1},   {24'd0, ey});
      check($sformatf("scan%0d_idx", p),  {29'd0, idx1}, 32'(li));
      check($sformatf("scan%0d_wrap", p), {31'd0, wrap1}, {31'd0, wr});
    end

    // now in first DRIVE cycle of idx=3: drop en, then re-enable
    en1 = 1'b0;
    step();
    check("endrop_y", {24'd0, y1}, 32'hFF);
    check("endrop_act", {31'd0, act1}, 32'd0);
    en1 = 1'b1;
    step();
    check("reen_y", {24'd0, y1}, 32'hFE);
    check("reen_idx", {29'd0, idx1}, 32'd0);
    check("reen_wrap", {31'd0, wrap1}, 32'd0);

    // scan -> direct with a request in the switching cycle
    mode1 = 1'b0; d1 = 3'd5; dv1 = 1'b1;
    step();
    check("todir_y", {24'd0, y1}, 32'hFF);
    dv1 = 1'b0;
    step();
    check("todir2_y", {24'd0, y1}, 32'hDF);
    check("todir2_idx", {29'd0, idx1}, 32'd5);

    // variant build
    rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b0; d2 = 4'd15; dv2 = 1'b1;
    step();
    check("v_d15_y", {16'd0, y2}, 32'h8000);
    check("v_d15_idx", {28'd0, idx2}, 32'd15);
    check("v_d15_act", {31'd0, act2}, 32'd1);
    mode2 = 1'b1; dv2 = 1'b0;
    step();
    check("v_mchg_y", {16'd0, y2}, 32'h0000);
    step();
    check("v_scan0_y", {16'd0, y2}, 32'h0001);
    check("v_scan0_wrap", {31'd0, wrap2}, 32'd0);
    for (int p = 1; p <= 65; p++) begin
      int pos, li;
      logic drv, wr;
      logic [15:0] ey;
      step();
      pos = p % 32;
      li  = pos / 2;
      drv = (pos % 2) == 0;
      wr  = (pos == 0);
      ey  = drv ? (16'd1 << li) : 16'h0000;
      check($sformatf("v_scan%0d_y", p),    {16'd0, y2},   {16'd0, ey});
      check($sformatf("v_scan%0d_idx", p),  {28'd0, idx2}, 32'(li));
      check($sformatf("v_scan%0d_wrap", p), {31'd0, wrap2}, {31'd0, wr});
    end

    @(posedge clk);
    #1;
    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
